// File: rtl/piano_vga_renderer_if.sv
// piano_vga_renderer_if: key-press inputs and VGA outputs of the piano renderer
interface piano_vga_renderer_if #(
    parameter int NUM_WHITE = 49
);
    logic [NUM_WHITE-1:0] iWhitePressed;
    logic [NUM_WHITE-1:0] iBlackPressed;
    logic                 oVGA_Hsync;
    logic                 oVGA_Vsync;
    logic [3:0]           oVGA_Red;
    logic [3:0]           oVGA_Green;
    logic [3:0]           oVGA_Blue;
    logic                 oDe;
    logic                 oFrameStart;

    modport master (
        output iWhitePressed, iBlackPressed,
        input  oVGA_Hsync, oVGA_Vsync, oVGA_Red, oVGA_Green, oVGA_Blue, oDe, oFrameStart
    );

    modport slave (
        input  iWhitePressed, iBlackPressed,
        output oVGA_Hsync, oVGA_Vsync, oVGA_Red, oVGA_Green, oVGA_Blue, oDe, oFrameStart
    );
endinterface

// File: rtl/piano_vga_renderer.sv
// piano_vga_renderer: parametrised VGA timing plus piano-keyboard pixel renderer
module piano_vga_renderer #(
    parameter int          H_DISP      = 1024,
    parameter int          H_FRONT     = 24,
    parameter int          H_SYNC      = 136,
    parameter int          H_BACK      = 160,
    parameter int          V_DISP      = 768,
    parameter int          V_FRONT     = 3,
    parameter int          V_SYNC      = 6,
    parameter int          V_BACK      = 29,
    parameter bit          HS_POL      = 1'b0,
    parameter bit          VS_POL      = 1'b0,
    parameter int          NUM_WHITE   = 49,
    parameter int          X0          = 20,
    parameter int          Y0          = 200,
    parameter int          PITCH       = 19,
    parameter int          GAP         = 1,
    parameter int          WHITE_H     = 160,
    parameter int          BLACK_W     = 11,
    parameter int          BLACK_H     = 100,
    parameter logic [11:0] BG_COLOR    = 12'h000,
    parameter logic [11:0] WHITE_COLOR = 12'hFFF,
    parameter logic [11:0] BLACK_COLOR = 12'h222,
    parameter logic [11:0] GAP_COLOR   = 12'h00F,
    parameter logic [11:0] PRESS_COLOR = 12'hFF0
) (
    input  logic                       clk_vga,
    input  logic                       iReset_n,
    piano_vga_renderer_if.slave        kb_io
);
    localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] HD     = 12'(H_DISP);
    localparam logic [11:0] VD     = 12'(V_DISP);
    localparam logic [11:0] HS_BEG = 12'(H_DISP + H_FRONT);
    localparam logic [11:0] HS_END = 12'(H_DISP + H_FRONT + H_SYNC);
    localparam logic [11:0] VS_BEG = 12'(V_DISP + V_FRONT);
    localparam logic [11:0] VS_END = 12'(V_DISP + V_FRONT + V_SYNC);
    localparam logic [11:0] WX     = 12'(X0);
    localparam logic [11:0] BX     = 12'(X0 + PITCH - BLACK_W / 2);
    localparam logic [11:0] P_LAST = 12'(PITCH - 1);
    localparam logic [11:0] P_GAP  = 12'(PITCH - GAP);
    localparam logic [11:0] NW     = 12'(NUM_WHITE);
    localparam logic [11:0] NB     = 12'(NUM_WHITE - 1);
    localparam logic [11:0] BW     = 12'(BLACK_W);
    localparam logic [11:0] Y_TOP  = 12'(Y0);
    localparam logic [11:0] Y_BLK  = 12'(Y0 + BLACK_H);
    localparam logic [11:0] Y_WHT  = 12'(Y0 + WHITE_H);
    localparam logic [NUM_WHITE-1:0] ONE = NUM_WHITE'(1);

    typedef enum logic [2:0] {C_BLANK, C_BLACK, C_GAP, C_WHITE, C_BG} cls_t;

    logic [11:0]          hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [11:0]          wi_q, wi_d, wo_q, wo_d;
    logic [11:0]          bi_q, bi_d, bo_q, bo_d;
    logic [2:0]           bn_q, bn_d;
    logic                 wact_q, wact_d, bact_q, bact_d;
    logic [NUM_WHITE-1:0] wsh_q, wsh_d, bsh_q, bsh_d;

    logic                 act, in_w, in_b, w_ok, b_ok;
    cls_t                 cls_q, cls_d;
    logic                 prs_q, prs_d;
    logic                 hs1_q, hs1_d, vs1_q, vs1_d, de1_q, fs1_q, fs1_d;

    logic [11:0]          rgb_q, rgb_d;
    logic                 hs_q, vs_q, de_q, fs_q;

    // Next raster position, key trackers (reloaded at their start column) and frame-latched presses
    always_comb begin
        hcnt_d = (hcnt_q == H_LAST) ? 12'd0 : hcnt_q + 12'd1;
        vcnt_d = (hcnt_q != H_LAST) ? vcnt_q : (vcnt_q == V_LAST) ? 12'd0 : vcnt_q + 12'd1;
        wact_d = (hcnt_d == WX) ? 1'b1 : (hcnt_d == 12'd0) ? 1'b0 : wact_q;
        wo_d   = (hcnt_d == WX || wo_q == P_LAST) ? 12'd0 : wo_q + 12'd1;
        wi_d   = (hcnt_d == WX) ? 12'd0 : (wo_q == P_LAST) ? wi_q + 12'd1 : wi_q;
        bact_d = (hcnt_d == BX) ? 1'b1 : (hcnt_d == 12'd0) ? 1'b0 : bact_q;
        bo_d   = (hcnt_d == BX || bo_q == P_LAST) ? 12'd0 : bo_q + 12'd1;
        bi_d   = (hcnt_d == BX) ? 12'd0 : (bo_q == P_LAST) ? bi_q + 12'd1 : bi_q;
        bn_d   = (hcnt_d == BX) ? 3'd0 : (bo_q != P_LAST) ? bn_q : (bn_q == 3'd6) ? 3'd0 : bn_q + 3'd1;
        wsh_d  = (hcnt_q == 12'd0 && vcnt_q == VD) ? kb_io.iWhitePressed : wsh_q;
        bsh_d  = (hcnt_q == 12'd0 && vcnt_q == VD) ? kb_io.iBlackPressed : bsh_q;
    end

    // Stage 0 state: counters, trackers and press shadows
    always_ff @(posedge clk_vga or negedge iReset_n) begin
        if (!iReset_n) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            wact_q <= 1'b0;
            wi_q   <= '0;
            wo_q   <= '0;
            bact_q <= 1'b0;
            bi_q   <= '0;
            bo_q   <= '0;
            bn_q   <= '0;
            wsh_q  <= '0;
            bsh_q  <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            wact_q <= wact_d;
            wi_q   <= wi_d;
            wo_q   <= wo_d;
            bact_q <= bact_d;
            bi_q   <= bi_d;
            bo_q   <= bo_d;
            bn_q   <= bn_d;
            wsh_q  <= wsh_d;
            bsh_q  <= bsh_d;
        end
    end

    // Classify the current pixel; black keys sit on top of the white keys and gaps
    always_comb begin
        act   = (hcnt_q < HD) && (vcnt_q < VD);
        in_w  = (vcnt_q >= Y_TOP) && (vcnt_q < Y_WHT);
        in_b  = (vcnt_q >= Y_TOP) && (vcnt_q < Y_BLK);
        w_ok  = wact_q && (wi_q < NW);
        b_ok  = bact_q && (bi_q < NB) && (bo_q < BW) && (bn_q != 3'd2) && (bn_q != 3'd6);
        cls_d = !act ? C_BLANK :
                (in_b && b_ok) ? C_BLACK :
                (in_w && w_ok && wo_q >= P_GAP) ? C_GAP :
                (in_w && w_ok) ? C_WHITE : C_BG;
        prs_d = (cls_d == C_BLACK) ? |(bsh_q & (ONE << bi_q)) :
                (cls_d == C_WHITE) ? |(wsh_q & (ONE << wi_q)) : 1'b0;
        hs1_d = (hcnt_q >= HS_BEG && hcnt_q < HS_END) ? HS_POL : ~HS_POL;
        vs1_d = (vcnt_q >= VS_BEG && vcnt_q < VS_END) ? VS_POL : ~VS_POL;
        fs1_d = (hcnt_q == 12'd0) && (vcnt_q == 12'd0);
    end

    // Stage 1 register: pixel class plus raw syncs, DE and frame-start
    always_ff @(posedge clk_vga or negedge iReset_n) begin
        if (!iReset_n) begin
            cls_q <= C_BLANK;
            prs_q <= 1'b0;
            hs1_q <= ~HS_POL;
            vs1_q <= ~VS_POL;
            de1_q <= 1'b0;
            fs1_q <= 1'b0;
        end else begin
            cls_q <= cls_d;
            prs_q <= prs_d;
            hs1_q <= hs1_d;
            vs1_q <= vs1_d;
            de1_q <= act;
            fs1_q <= fs1_d;
        end
    end

    // Map pixel class to colour; a pressed key overrides its own colour only
    always_comb begin
        rgb_d = (cls_q == C_BLANK) ? 12'h000 :
                prs_q ? PRESS_COLOR :
                (cls_q == C_BLACK) ? BLACK_COLOR :
                (cls_q == C_GAP) ? GAP_COLOR :
                (cls_q == C_WHITE) ? WHITE_COLOR : BG_COLOR;
    end

    // Stage 2 register: colour aligned with the delayed syncs, DE and frame-start
    always_ff @(posedge clk_vga or negedge iReset_n) begin
        if (!iReset_n) begin
            rgb_q <= '0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            de_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= hs1_q;
            vs_q  <= vs1_q;
            de_q  <= de1_q;
            fs_q  <= fs1_q;
        end
    end

    assign kb_io.oVGA_Hsync  = hs_q;
    assign kb_io.oVGA_Vsync  = vs_q;
    assign kb_io.oVGA_Red    = rgb_q[11:8];
    assign kb_io.oVGA_Green  = rgb_q[7:4];
    assign kb_io.oVGA_Blue   = rgb_q[3:0];
    assign kb_io.oDe         = de_q;
    assign kb_io.oFrameStart = fs_q;
endmodule
